branch_predict_table: RTL and testbench
=======================================

# branch_predict_table

Indexed table of 2-bit saturating branch counters sitting directly upstream of the per-branch predictor FSM. It produces a taken/not-taken prediction per fetched branch PC, and tracks in-flight predictions in order. When each outcome resolves, it applies the saturating update to the correct entry and flags mispredictions to the fetch redirect logic.

## Interface
- `INDEX_BITS`, default 4: table has 2^INDEX_BITS entries.
- `PC_WIDTH`, default 32: branch PC width.
- `QUEUE_DEPTH`, default 4: maximum in-flight (predicted, unresolved) branches.
- `i_clock`  in  1  sole clock, all state on rising edge.
- `i_init`  in  1  reset, synchronous, active-high.
- `i_lookup_valid`  in  1  fetch presents a branch PC.
- `i_lookup_pc`  in  PC_WIDTH  branch PC; index = `i_lookup_pc[INDEX_BITS+1:2]`.
- `o_lookup_ready`  out  1  lookup accepted when valid & ready.
- `o_predict_valid`  out  1  one-cycle pulse, prediction for last accepted lookup.
- `o_predict_taken`  out  1  1 = predict taken.
- `i_resolve_valid`  in  1  oldest in-flight branch resolved this cycle.
- `i_branch_result`  in  1  actual outcome, 1 = taken.
- `o_mispredict`  out  1  one-cycle pulse, resolved outcome differed from prediction.
- `o_resolve_error`  out  1  one-cycle pulse, resolve arrived with queue empty.
- `o_inflight`  out  $clog2(QUEUE_DEPTH+1)  current queue occupancy.

## Operation
- Counter encoding: 0 STRONGLY_TAKEN, 1 WEAKLY_TAKEN, 2 WEAKLY_NOT_TAKEN, 3 STRONGLY_NOT_TAKEN. Prediction taken iff bit[1] == 0.
- Update rule: result taken → state-1 saturating at 0. Result not taken → state+1 saturating at 3.
- Control FSM has two states, CLEAR and RUN.
  - CLEAR: `i_init` forces CLEAR with sweep pointer = 0. Each cycle writes WEAKLY_TAKEN to the entry at the pointer, then increments the pointer. After entry 2^INDEX_BITS-1 is written, the FSM moves to RUN.
  - RUN: normal operation; leaves only on `i_init`.
- `o_lookup_ready` = RUN && occupancy < QUEUE_DEPTH. A full queue blocks pushes even if a pop occurs the same cycle.
- Accepted lookup: read the entry combinationally, push {index, predicted_taken} into the queue, and register the prediction onto the outputs.
- Resolve with queue non-empty: pop the head. Apply the update rule to the table's current value at the head index, not a snapshot taken at lookup. Set `o_mispredict` = (head.predicted_taken != `i_branch_result`).
- Resolve with queue empty, or while in CLEAR: `o_resolve_error` = 1; table and queue are unchanged.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- Lookup and update to the same index in the same cycle: the lookup sees the pre-update value (no bypass).
- An empty queue with simultaneous lookup and resolve counts as a resolve error; the lookup is still accepted.
- `i_init` dominates everything:
  - queue flushed; occupancy 0;
  - same-cycle lookup/resolve ignored;
  - the sweep restarts even if a sweep is already in progress.

## Timing
- Reset values (cycle after `i_init`): `o_lookup_ready` 0, `o_predict_valid` 0, `o_predict_taken` 0, `o_mispredict` 0, `o_resolve_error` 0, `o_inflight` 0.
- `o_lookup_ready` rises exactly 2^INDEX_BITS cycles after the last `i_init` cycle (16 by default).
- Lookup accepted in cycle N → `o_predict_valid`/`o_predict_taken` valid in cycle N+1, for one cycle.
- Resolve in cycle N → `o_mispredict`/`o_resolve_error` in cycle N+1. The table write is visible to lookups from cycle N+1.
- `o_inflight` and `o_lookup_ready` reflect push/pop from the previous edge (registered occupancy).
- Queue pointers wrap modulo QUEUE_DEPTH; QUEUE_DEPTH is not required to be a power of two.

## Structure
- Shared package `branch_predict_pkg`:
  - the four counter-state constants / 2-bit state typedef;
  - `counter_next(state, taken)` function;
  - `counter_predicts_taken(state)` function.
  - The existing predictor FSM imports the same package.
- Sub-module `branch_inflight_fifo`: synchronous FIFO of {index, predicted_taken}, parameterized width/depth, with push, pop, full, empty and count outputs.
- The table array, sweep pointer and CLEAR/RUN FSM live in the top module.

## Test plan
1. **Reset sweep.** Pulse `i_init` for 1 cycle. `o_lookup_ready` stays 0 for 16 cycles, then goes to 1. Lookup PC 0x0 → `o_predict_taken` = 1.
2. **Training and saturation.** Serially lookup+resolve PC 0x44 three times, all not taken:
   - predictions 1,0,0;
   - `o_mispredict` 1,0,0;
   - entry ends at 3.
   Two further taken resolves → next prediction 1.
3. **Aliasing.** Train PC 0x40 to STRONGLY_NOT_TAKEN. Lookup PC 0x80 (same index 0) → predict 0. Lookup PC 0x44 → predict 1.
4. **Queue full.** Four back-to-back lookups with no resolve → `o_inflight` = 4, `o_lookup_ready` = 0. One resolve → `o_inflight` = 3 and ready = 1 on the next cycle.
5. **Empty resolve.** `i_resolve_valid` with queue empty → `o_resolve_error` pulses 1 cycle. `o_mispredict` = 0; no entry changes.
6. **Mid-operation reset.** With 3 branches in flight, assert `i_init` together with a resolve:
   - next cycle `o_inflight` = 0, no mispredict pulse;
   - a full 16-cycle sweep runs;
   - all entries read back as taken.

Source files
------------

// File: rtl/branch_predict_pkg.sv
// Shared definitions for the 2-bit saturating branch counters.
// Used by branch_predict_table and by the per-branch predictor FSM.
//   counter_t                   2-bit counter state
//   counter_next(state, taken)  saturating update toward the resolved outcome
//   counter_predicts_taken(s)   prediction derived from a counter state
package branch_predict_pkg;

  typedef logic [1:0] counter_t;

  localparam counter_t StronglyTaken    = 2'd0;
  localparam counter_t WeaklyTaken      = 2'd1;
  localparam counter_t WeaklyNotTaken   = 2'd2;
  localparam counter_t StronglyNotTaken = 2'd3;

  // Taken moves toward 0, not-taken moves toward 3; both saturate.
  function automatic counter_t counter_next(input counter_t state, input logic taken);
    counter_t next_state;
    if (taken) begin
      next_state = (state == StronglyTaken) ? state : state - 2'd1;
    end else begin
      next_state = (state == StronglyNotTaken) ? state : state + 2'd1;
    end
    return next_state;
  endfunction

  function automatic logic counter_predicts_taken(input counter_t state);
    return (state == StronglyTaken) || (state == WeaklyTaken);
  endfunction

endpackage

// File: rtl/branch_predict_table_if.sv
// Fetch/resolve bus between the front end and branch_predict_table.
//   master: fetch side, drives lookups and resolved outcomes
//   slave : predictor table, returns ready, predictions and status pulses
interface branch_predict_table_if #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned QUEUE_DEPTH = 4
);

  logic                               i_lookup_valid;
  logic [PC_WIDTH-1:0]                i_lookup_pc;
  logic                               o_lookup_ready;
  logic                               o_predict_valid;
  logic                               o_predict_taken;
  logic                               i_resolve_valid;
  logic                               i_branch_result;
  logic                               o_mispredict;
  logic                               o_resolve_error;
  logic [$clog2(QUEUE_DEPTH+1)-1:0]   o_inflight;

  modport master (
    output i_lookup_valid, i_lookup_pc, i_resolve_valid, i_branch_result,
    input  o_lookup_ready, o_predict_valid, o_predict_taken, o_mispredict,
           o_resolve_error, o_inflight
  );

  modport slave (
    input  i_lookup_valid, i_lookup_pc, i_resolve_valid, i_branch_result,
    output o_lookup_ready, o_predict_valid, o_predict_taken, o_mispredict,
           o_resolve_error, o_inflight
  );

endinterface

// File: rtl/branch_inflight_fifo.sv
// Synchronous FIFO holding in-flight {index, predicted_taken} records.
//   i_clock/i_init  clock, synchronous active-high flush
//   i_push/i_data   write request (ignored when full)
//   i_pop           drop head (ignored when empty)
//   o_data          head entry
//   o_full/o_empty/o_count  occupancy status
module branch_inflight_fifo #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         i_clock,
  input  logic                         i_init,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [WIDTH-1:0]             i_data,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CountW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [CountW-1:0] r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_count == CountW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clock) begin
    if (i_init) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Explicit wrap so DEPTH need not be a power of two.
      if (w_do_push) r_wr_ptr <= (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + PtrW'(1);
      if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + PtrW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CountW'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CountW'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_init && w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/branch_predict_table.sv
// Table of 2-bit saturating branch counters with in-order tracking of
// in-flight predictions.
//   i_clock  clock
//   i_init   synchronous active-high reset; restarts the table-clearing sweep
//   io_bus   slave side of branch_predict_table_if (lookup, predict, resolve,
//            mispredict/resolve-error pulses, in-flight count)
module branch_predict_table
  import branch_predict_pkg::*;
#(
  parameter int unsigned INDEX_BITS  = 4,
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic                   i_clock,
  input  logic                   i_init,
  branch_predict_table_if.slave  io_bus
);

  localparam int unsigned Entries = 2 ** INDEX_BITS;
  localparam int unsigned EntryW  = INDEX_BITS + 1;
  localparam int unsigned CountW  = $clog2(QUEUE_DEPTH + 1);
  localparam logic [INDEX_BITS-1:0] LastIdx = '1;

  localparam logic [0:0] StClear = 1'b0;
  localparam logic [0:0] StRun   = 1'b1;

  counter_t              r_table [Entries];
  logic [0:0]            r_state;
  logic [INDEX_BITS-1:0] r_sweep_ptr;
  logic                  r_predict_valid;
  logic                  r_predict_taken;
  logic                  r_mispredict;
  logic                  r_resolve_error;

  logic [INDEX_BITS-1:0] w_lookup_idx;
  logic                  w_lookup_ready;
  logic                  w_accept;
  logic                  w_pred_taken;
  logic                  w_pop;
  logic                  w_resolve_error;
  logic [EntryW-1:0]     w_head;
  logic [INDEX_BITS-1:0] w_head_idx;
  logic                  w_head_pred;
  logic                  w_full;
  logic                  w_empty;
  logic [CountW-1:0]     w_count;
  logic                  w_unused_pc;

  assign w_lookup_idx = io_bus.i_lookup_pc[INDEX_BITS+1:2];
  assign w_unused_pc  = ^{io_bus.i_lookup_pc[PC_WIDTH-1:INDEX_BITS+2],
                          io_bus.i_lookup_pc[1:0]};

  // Occupancy is registered, so a full queue stays blocked even with a same-cycle pop.
  assign w_lookup_ready  = (r_state == StRun) && !w_full;
  assign w_accept        = io_bus.i_lookup_valid && w_lookup_ready;
  assign w_pred_taken    = counter_predicts_taken(r_table[w_lookup_idx]);
  assign w_pop           = io_bus.i_resolve_valid && (r_state == StRun) && !w_empty;
  assign w_resolve_error = io_bus.i_resolve_valid && ((r_state == StClear) || w_empty);
  assign w_head_idx      = w_head[EntryW-1:1];
  assign w_head_pred     = w_head[0];

  branch_inflight_fifo #(
    .WIDTH (EntryW),
    .DEPTH (QUEUE_DEPTH)
  ) u_inflight_fifo (
    .i_clock (i_clock),
    .i_init  (i_init),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_data  ({w_lookup_idx, w_pred_taken}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge i_clock) begin
    if (i_init) begin
      r_state         <= StClear;
      r_sweep_ptr     <= '0;
      r_predict_valid <= 1'b0;
      r_predict_taken <= 1'b0;
      r_mispredict    <= 1'b0;
      r_resolve_error <= 1'b0;
    end else begin
      if (r_state == StClear) begin
        r_sweep_ptr <= r_sweep_ptr + 1'b1;
        if (r_sweep_ptr == LastIdx) r_state <= StRun;
      end
      r_predict_valid <= w_accept;
      r_predict_taken <= w_accept && w_pred_taken;
      r_mispredict    <= w_pop && (w_head_pred != io_bus.i_branch_result);
      r_resolve_error <= w_resolve_error;
    end
  end

  // Update uses the live entry at the head index; lookups this cycle see the old value.
  always_ff @(posedge i_clock) begin
    if (!i_init) begin
      if (r_state == StClear) begin
        r_table[r_sweep_ptr] <= WeaklyTaken;
      end else if (w_pop) begin
        r_table[w_head_idx] <= counter_next(r_table[w_head_idx], io_bus.i_branch_result);
      end
    end
  end

  assign io_bus.o_lookup_ready  = w_lookup_ready;
  assign io_bus.o_predict_valid = r_predict_valid;
  assign io_bus.o_predict_taken = r_predict_taken;
  assign io_bus.o_mispredict    = r_mispredict;
  assign io_bus.o_resolve_error = r_resolve_error;
  assign io_bus.o_inflight      = w_count;

endmodule

// File: tb/tb_branch_predict_table.sv
module tb_branch_predict_table;

  logic clk;
  logic init;
  int   n_checks;
  int   n_errors;

  branch_predict_table_if #(.PC_WIDTH(32), .QUEUE_DEPTH(4)) bus ();

  branch_predict_table #(
    .INDEX_BITS  (4),
    .PC_WIDTH    (32),
    .QUEUE_DEPTH (4)
  ) dut (
    .i_clock (clk),
    .i_init  (init),
    .io_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lookup(input logic [31:0] pc, input logic exp_taken, input string tag);
    bus.i_lookup_valid = 1'b1;
    bus.i_lookup_pc    = pc;
    tick();
    bus.i_lookup_valid = 1'b0;
    check({tag, ".pv"}, 32'(bus.o_predict_valid), 32'd1);
    check({tag, ".taken"}, 32'(bus.o_predict_taken), 32'(exp_taken));
    check({tag, ".mis_idle"}, 32'(bus.o_mispredict), 32'd0);
  endtask

  task automatic do_resolve(input logic result, input logic exp_mis, input string tag);
    bus.i_resolve_valid = 1'b1;
    bus.i_branch_result = result;
    tick();
    bus.i_resolve_valid = 1'b0;
    check({tag, ".mis"}, 32'(bus.o_mispredict), 32'(exp_mis));
    check({tag, ".err"}, 32'(bus.o_resolve_error), 32'd0);
    check({tag, ".pv_idle"}, 32'(bus.o_predict_valid), 32'd0);
  endtask

  // Call right after the last init cycle: ready low for 16 cycles, then high.
  task automatic sweep_check(input string tag);
    check({tag, ".ready_c1"}, 32'(bus.o_lookup_ready), 32'd0);
    for (int i = 2; i <= 16; i++) begin
      tick();
      check({tag, ".ready_low"}, 32'(bus.o_lookup_ready), 32'd0);
    end
    tick();
    check({tag, ".ready_high"}, 32'(bus.o_lookup_ready), 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    init = 1'b1;
    bus.i_lookup_valid  = 1'b0;
    bus.i_lookup_pc     = '0;
    bus.i_resolve_valid = 1'b0;
    bus.i_branch_result = 1'b0;

    // Test 1: reset values and sweep.
    tick();
    init = 1'b0;
    check("rst.pv", 32'(bus.o_predict_valid), 32'd0);
    check("rst.taken", 32'(bus.o_predict_taken), 32'd0);
    check("rst.mis", 32'(bus.o_mispredict), 32'd0);
    check("rst.err", 32'(bus.o_resolve_error), 32'd0);
    check("rst.inflight", 32'(bus.o_inflight), 32'd0);
    sweep_check("sweep1");
    do_lookup(32'h0, 1'b1, "t1.lk0");
    check("t1.inflight", 32'(bus.o_inflight), 32'd1);
    do_resolve(1'b1, 1'b0, "t1.rs0");              // entry0 -> 0
    check("t1.inflight0", 32'(bus.o_inflight), 32'd0);

    // Test 2: train PC 0x44 (index 1) not-taken, then back.
    do_lookup(32'h44, 1'b1, "t2.lk1");
    do_resolve(1'b0, 1'b1, "t2.rs1");              // 1 -> 2
    do_lookup(32'h44, 1'b0, "t2.lk2");             // mispredict pulse dropped
    do_resolve(1'b0, 1'b0, "t2.rs2");              // 2 -> 3
    do_lookup(32'h44, 1'b0, "t2.lk3");
    do_resolve(1'b0, 1'b0, "t2.rs3");              // saturate at 3
    do_lookup(32'h44, 1'b0, "t2.lk4");
    do_resolve(1'b1, 1'b1, "t2.rs4");              // 3 -> 2
    do_lookup(32'h44, 1'b0, "t2.lk5");
    do_resolve(1'b1, 1'b1, "t2.rs5");              // 2 -> 1
    do_lookup(32'h44, 1'b1, "t2.lk6");
    do_resolve(1'b1, 1'b0, "t2.rs6");              // 1 -> 0

    // Test 3: aliasing on index 0.
    do_lookup(32'h40, 1'b1, "t3.lk1");
    do_resolve(1'b0, 1'b1, "t3.rs1");              // 0 -> 1
    do_lookup(32'h40, 1'b1, "t3.lk2");
    do_resolve(1'b0, 1'b1, "t3.rs2");              // 1 -> 2
    do_lookup(32'h40, 1'b0, "t3.lk3");
    do_resolve(1'b0, 1'b0, "t3.rs3");              // 2 -> 3
    do_lookup(32'h80, 1'b0, "t3.alias");
    do_resolve(1'b0, 1'b0, "t3.rs4");
    do_lookup(32'h44, 1'b1, "t3.idx1");
    do_resolve(1'b1, 1'b0, "t3.rs5");

    // Test 4: fill the queue (entries 0..3 = 3,0,1,1).
    bus.i_lookup_valid = 1'b1;
    bus.i_lookup_pc = 32'h0; tick();
    check("t4.p0", 32'(bus.o_predict_taken), 32'd0);
    bus.i_lookup_pc = 32'h4; tick();
    check("t4.p1", 32'(bus.o_predict_taken), 32'd1);
    bus.i_lookup_pc = 32'h8; tick();
    check("t4.p2", 32'(bus.o_predict_taken), 32'd1);
    bus.i_lookup_pc = 32'hC; tick();
    check("t4.p3", 32'(bus.o_predict_taken), 32'd1);
    check("t4.full_inflight", 32'(bus.o_inflight), 32'd4);
    check("t4.full_ready", 32'(bus.o_lookup_ready), 32'd0);
    bus.i_lookup_pc = 32'h10; tick();
    check("t4.blocked_pv", 32'(bus.o_predict_valid), 32'd0);
    check("t4.blocked_inflight", 32'(bus.o_inflight), 32'd4);
    // Pop while full with a lookup pending: pop happens, push is blocked.
    bus.i_resolve_valid = 1'b1;
    bus.i_branch_result = 1'b0;
    tick();
    bus.i_lookup_valid  = 1'b0;
    bus.i_resolve_valid = 1'b0;
    check("t4.pop_inflight", 32'(bus.o_inflight), 32'd3);
    check("t4.pop_ready", 32'(bus.o_lookup_ready), 32'd1);
    check("t4.pop_pv", 32'(bus.o_predict_valid), 32'd0);
    check("t4.pop_mis", 32'(bus.o_mispredict), 32'd0);
    do_resolve(1'b1, 1'b0, "t4.d1");               // idx1 stays 0
    do_resolve(1'b1, 1'b0, "t4.d2");               // idx2 1 -> 0
    do_resolve(1'b0, 1'b1, "t4.d3");               // idx3 1 -> 2
    check("t4.drained", 32'(bus.o_inflight), 32'd0);
    do_lookup(32'h8, 1'b1, "t4.lk8");
    // Simultaneous push and pop: occupancy unchanged.
    bus.i_lookup_valid  = 1'b1;
    bus.i_lookup_pc     = 32'hC;
    bus.i_resolve_valid = 1'b1;
    bus.i_branch_result = 1'b1;
    tick();
    bus.i_lookup_valid  = 1'b0;
    bus.i_resolve_valid = 1'b0;
    check("t4.pp_pv", 32'(bus.o_predict_valid), 32'd1);
    check("t4.pp_taken", 32'(bus.o_predict_taken), 32'd0);
    check("t4.pp_mis", 32'(bus.o_mispredict), 32'd0);
    check("t4.pp_inflight", 32'(bus.o_inflight), 32'd1);
    do_resolve(1'b0, 1'b0, "t4.rsC");              // idx3 2 -> 3

    // Test 5: resolves with an empty queue.
    for (int i = 0; i < 2; i++) begin
      bus.i_resolve_valid = 1'b1;
      bus.i_branch_result = 1'b0;
      tick();
      bus.i_resolve_valid = 1'b0;
      check("t5.err", 32'(bus.o_resolve_error), 32'd1);
      check("t5.mis", 32'(bus.o_mispredict), 32'd0);
      check("t5.inflight", 32'(bus.o_inflight), 32'd0);
      tick();
      check("t5.err_pulse", 32'(bus.o_resolve_error), 32'd0);
    end
    // Empty-queue resolve alongside a lookup: error, lookup still accepted.
    bus.i_lookup_valid  = 1'b1;
    bus.i_lookup_pc     = 32'h8;
    bus.i_resolve_valid = 1'b1;
    bus.i_branch_result = 1'b0;
    tick();
    bus.i_lookup_valid  = 1'b0;
    bus.i_resolve_valid = 1'b0;
    check("t5.both_err", 32'(bus.o_resolve_error), 32'd1);
    check("t5.both_pv", 32'(bus.o_predict_valid), 32'd1);
    check("t5.both_taken", 32'(bus.o_predict_taken), 32'd1);
    check("t5.both_inflight", 32'(bus.o_inflight), 32'd1);
    do_resolve(1'b1, 1'b0, "t5.rs");

    // Test 6: reset with branches in flight, plus a restarted sweep.
    do_lookup(32'h4, 1'b1, "t6.lk1");
    do_lookup(32'h8, 1'b1, "t6.lk2");
    do_lookup(32'hC, 1'b0, "t6.lk3");
    check("t6.inflight3", 32'(bus.o_inflight), 32'd3);
    init = 1'b1;
    bus.i_resolve_valid = 1'b1;
    bus.i_branch_result = 1'b0;
    tick();
    init = 1'b0;
    bus.i_resolve_valid = 1'b0;
    check("t6.inflight0", 32'(bus.o_inflight), 32'd0);
    check("t6.mis", 32'(bus.o_mispredict), 32'd0);
    check("t6.err", 32'(bus.o_resolve_error), 32'd0);
    check("t6.ready", 32'(bus.o_lookup_ready), 32'd0);
    repeat (5) tick();
    init = 1'b1;
    tick();
    init = 1'b0;
    sweep_check("sweep2");
    for (int i = 0; i < 16; i++) begin
      do_lookup(32'(i * 4), 1'b1, "t6.readback");
      do_resolve(1'b1, 1'b0, "t6.readback_rs");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
